// File: rtl/spi_pkg.sv
// Shared SPI sensor-link definitions: FSM states, instruction codes and
// register map addresses used by both the responder and the master FSM.
package spi_pkg;

  typedef enum logic [2:0] {
    IDLE,
    CMD,
    ADDR,
    DATA,
    IGNORE
  } spi_state_e;

  localparam logic [7:0] CMD_WRITE      = 8'h0A;
  localparam logic [7:0] CMD_READ       = 8'h0B;
  localparam logic [5:0] REG_DEVID      = 6'h00;
  localparam logic [5:0] REG_XDATA_L    = 6'h0E;
  localparam logic [5:0] REG_SOFT_RESET = 6'h1F;
  localparam logic [7:0] SOFT_RESET_KEY = 8'h52;
  localparam logic [5:0] REG_POWER_CTL  = 6'h2D;
  localparam logic [1:0] MEAS_MODE      = 2'b10;

endpackage

// File: rtl/spi_sync_edge.sv
// Multi-flop synchronizer for one asynchronous input, with single-cycle
// rise/fall pulses derived from the synchronized copy.
module spi_sync_edge #(
  parameter int   STAGES    = 2,
  parameter logic RESET_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic din,
  output logic q,
  output logic rise,
  output logic fall
);

  logic [STAGES-1:0] sync_sr;
  logic              prev;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_sr <= {STAGES{RESET_VAL}};
      prev    <= RESET_VAL;
    end else begin
      sync_sr <= {sync_sr[STAGES-2:0], din};
      prev    <= sync_sr[STAGES-1];
    end
  end

  assign q    = sync_sr[STAGES-1];
  assign rise = q & ~prev;
  assign fall = ~q & prev;

endmodule

// File: rtl/spi_sensor_responder.sv
// SPI mode-0 slave exposing a 64-byte sensor register map with auto-increment
// bursts, read-only ID/sample bytes, a keyed soft reset and coherent samples.
//
// state  | meaning
// IDLE   | deselected, waiting for cs_n fall
// CMD    | shifting in the instruction byte
// ADDR   | shifting in the start address
// DATA   | burst of data bytes, write or read
// IGNORE | unknown instruction, miso held low until deselect
module spi_sensor_responder
  import spi_pkg::*;
#(
  parameter logic [7:0] DEVID       = 8'hAD,
  parameter int         SYNC_STAGES = 2,
  parameter int         SAMPLE_W    = 48
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                sclk,
  input  logic                cs_n,
  input  logic                mosi,
  output logic                miso,
  output logic                miso_oe,
  input  logic [SAMPLE_W-1:0] sample_in,
  input  logic                sample_valid,
  output logic                meas_mode,
  output logic                soft_rst_pulse
);

  localparam int N_SAMPLE = SAMPLE_W / 8;

  logic sclk_q, sclk_rise, sclk_fall;
  logic cs_q, cs_rise, cs_fall;
  logic mosi_q, mosi_rise, mosi_fall;

  spi_sync_edge #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_sclk (
    .clk(clk), .rst_n(rst_n), .din(sclk), .q(sclk_q), .rise(sclk_rise), .fall(sclk_fall)
  );
  spi_sync_edge #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_sync_cs (
    .clk(clk), .rst_n(rst_n), .din(cs_n), .q(cs_q), .rise(cs_rise), .fall(cs_fall)
  );
  spi_sync_edge #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_mosi (
    .clk(clk), .rst_n(rst_n), .din(mosi), .q(mosi_q), .rise(mosi_rise), .fall(mosi_fall)
  );

  logic unused_edges;
  assign unused_edges = ^{sclk_q, mosi_rise, mosi_fall};

  spi_state_e           state;
  logic [2:0]           bit_cnt;
  logic [7:0]           rx_sh;
  logic [7:0]           tx_sh;
  logic [5:0]           addr;
  logic                 is_read;
  logic                 wr_pend;
  logic [5:0]           wr_addr;
  logic [7:0]           wr_data;
  logic [7:0]           regs [64];
  logic [SAMPLE_W-1:0]  sample_stage;
  logic [SAMPLE_W-1:0]  sample_vis;

  logic [7:0] rx_byte;
  logic [5:0] rd_addr;
  logic [7:0] rd_byte;
  logic       read_data;

  function automatic logic is_writable(input logic [5:0] a);
    return (a != REG_DEVID) && (a != REG_SOFT_RESET) &&
           !((a >= REG_XDATA_L) && (a < REG_XDATA_L + 6'(N_SAMPLE)));
  endfunction

  assign rx_byte   = {rx_sh[6:0], mosi_q};
  assign read_data = (state == DATA) && is_read;

  // Address of the byte to preload into the shadow register at byte completion
  always_comb begin
    rd_addr = (state == ADDR) ? rx_byte[5:0] : addr + 6'd1;
    rd_byte = regs[rd_addr];
    if (rd_addr == REG_DEVID) begin
      rd_byte = DEVID;
    end else if (rd_addr == REG_SOFT_RESET) begin
      rd_byte = '0;
    end else begin
      for (int i = 0; i < N_SAMPLE; i++) begin
        if (rd_addr == REG_XDATA_L + 6'(i)) rd_byte = sample_vis[i*8 +: 8];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= IDLE;
      bit_cnt        <= '0;
      rx_sh          <= '0;
      tx_sh          <= '0;
      addr           <= '0;
      is_read        <= 1'b0;
      wr_pend        <= 1'b0;
      wr_addr        <= '0;
      wr_data        <= '0;
      miso           <= 1'b0;
      soft_rst_pulse <= 1'b0;
      sample_stage   <= '0;
      sample_vis     <= '0;
      for (int i = 0; i < 64; i++) regs[i] <= '0;
    end else begin
      soft_rst_pulse <= 1'b0;
      wr_pend        <= 1'b0;

      if (sample_valid) sample_stage <= sample_in;
      // Visible samples only move while deselected so bursts stay coherent
      if (cs_q) sample_vis <= sample_valid ? sample_in : sample_stage;

      if (wr_pend) begin
        if (wr_addr == REG_SOFT_RESET) begin
          if (wr_data == SOFT_RESET_KEY) begin
            for (int i = 0; i < 64; i++) regs[i] <= '0;
            soft_rst_pulse <= 1'b1;
          end
        end else if (is_writable(wr_addr)) begin
          regs[wr_addr] <= wr_data;
        end
      end

      if (cs_rise) begin
        state   <= IDLE;
        bit_cnt <= '0;
        miso    <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            if (cs_fall) begin
              state   <= CMD;
              bit_cnt <= '0;
            end
          end
          CMD, ADDR, DATA: begin
            if (sclk_rise) begin
              rx_sh   <= rx_byte;
              bit_cnt <= bit_cnt + 3'd1;
              if (bit_cnt == 3'd7) begin
                if (state == CMD) begin
                  is_read <= (rx_byte == CMD_READ);
                  state   <= ((rx_byte == CMD_READ) || (rx_byte == CMD_WRITE)) ? ADDR : IGNORE;
                end else if (state == ADDR) begin
                  addr  <= rx_byte[5:0];
                  tx_sh <= rd_byte;
                  state <= DATA;
                end else begin
                  addr  <= addr + 6'd1;
                  tx_sh <= rd_byte;
                  if (!is_read) begin
                    wr_pend <= 1'b1;
                    wr_addr <= addr;
                    wr_data <= rx_byte;
                  end
                end
              end
            end
          end
          IGNORE: ;
          default: state <= IDLE;
        endcase

        if (read_data && sclk_fall) begin
          miso  <= tx_sh[7];
          tx_sh <= {tx_sh[6:0], 1'b0};
        end else if (!read_data) begin
          miso <= 1'b0;
        end
      end
    end
  end

  assign miso_oe   = ~cs_q;
  assign meas_mode = (regs[REG_POWER_CTL][1:0] == MEAS_MODE);

endmodule

// File: tb/tb_spi_sensor_responder.sv
// Directed and randomized SPI transactions against a behavioural model of
// the sensor register map (flat array, address wrap, RO rules, soft reset).
module tb_spi_sensor_responder;

  localparam int HALF = 6;

  logic        clk = 1'b0;
  logic        rst_n, sclk, cs_n, mosi, sample_valid;
  logic [47:0] sample_in;
  logic        miso, miso_oe, meas_mode, soft_rst_pulse;

  int checks = 0;
  int errors = 0;
  int pulse_cnt = 0;

  spi_sensor_responder dut (
    .clk(clk), .rst_n(rst_n), .sclk(sclk), .cs_n(cs_n), .mosi(mosi),
    .miso(miso), .miso_oe(miso_oe), .sample_in(sample_in),
    .sample_valid(sample_valid), .meas_mode(meas_mode),
    .soft_rst_pulse(soft_rst_pulse)
  );

  always #5 clk = ~clk;

  always @(posedge clk) if (soft_rst_pulse === 1'b1) pulse_cnt <= pulse_cnt + 1;

  // Reference model
  logic [7:0]  m_regs [64];
  logic [47:0] m_vis, m_stage;
  int          m_pulses = 0;

  logic [7:0]  dq [$];
  int          strobe_idx = -1;
  logic [47:0] strobe_val;

  function automatic bit m_writable(input logic [5:0] a);
    return !(a == 0 || (a >= 14 && a <= 19) || a == 31);
  endfunction

  function automatic logic [7:0] m_read(input logic [5:0] a);
    if (a == 0) return 8'hAD;
    if (a >= 14 && a <= 19) return m_vis[(int'(a) - 14) * 8 +: 8];
    if (a == 31) return 8'h00;
    return m_regs[a];
  endfunction

  function automatic void m_write(input logic [5:0] a, input logic [7:0] d);
    if (a == 31) begin
      if (d == 8'h52) begin
        for (int i = 0; i < 64; i++) if (m_writable(6'(i))) m_regs[i] = 8'h00;
        m_pulses++;
      end
    end else if (m_writable(a)) begin
      m_regs[a] = d;
    end
  endfunction

  function automatic void m_reset();
    for (int i = 0; i < 64; i++) m_regs[i] = 8'h00;
    m_vis   = '0;
    m_stage = '0;
  endfunction

  function automatic logic m_meas();
    return m_regs[6'h2D][1:0] == 2'b10;
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic spi_bits(input logic [7:0] tx, input int n, output logic [7:0] rx);
    rx = '0;
    for (int i = 0; i < n; i++) begin
      mosi = tx[7-i];
      repeat (HALF) @(posedge clk);
      #1;
      rx[7-i] = miso;
      sclk = 1'b1;
      repeat (HALF) @(posedge clk);
      #1;
      sclk = 1'b0;
    end
  endtask

  task automatic strobe(input logic [47:0] v);
    sample_in    = v;
    sample_valid = 1'b1;
    @(posedge clk);
    #1;
    sample_valid = 1'b0;
    m_stage = v;
    if (cs_n) m_vis = v;
  endtask

  task automatic txn(input logic [7:0] cmd, input logic [5:0] a);
    logic [7:0] rx, exp;
    logic [5:0] ma;
    cs_n = 1'b0;
    repeat (HALF) @(posedge clk);
    #1;
    check("miso_oe_selected", miso_oe, 1);
    spi_bits(cmd, 8, rx);
    check("miso_during_cmd", rx, 0);
    spi_bits({2'b00, a}, 8, rx);
    ma = a;
    for (int i = 0; i < dq.size(); i++) begin
      if (i == strobe_idx) strobe(strobe_val);
      exp = m_read(ma);
      spi_bits(dq[i], 8, rx);
      if (cmd == 8'h0B) check($sformatf("read_data@%02h", ma), rx, exp);
      else if (cmd == 8'h0A) m_write(ma, dq[i]);
      else check("ignore_miso", rx, 0);
      ma = ma + 6'd1;
    end
    cs_n = 1'b1;
    repeat (2 * HALF) @(posedge clk);
    #1;
    m_vis = m_stage;
    check("miso_oe_deselected", miso_oe, 0);
    check("meas_mode", meas_mode, m_meas());
    check("soft_rst_pulses", pulse_cnt, m_pulses);
  endtask

  task automatic fill(input int n, input logic [7:0] v);
    dq.delete();
    for (int i = 0; i < n; i++) dq.push_back(v);
  endtask

  initial begin
    logic [7:0]  rx;
    logic [63:0] r64;
    rst_n = 1'b0; sclk = 1'b0; cs_n = 1'b1; mosi = 1'b0;
    sample_in = '0; sample_valid = 1'b0;
    m_reset();
    repeat (3) @(posedge clk);
    #1;
    check("reset_miso", miso, 0);
    check("reset_miso_oe", miso_oe, 0);
    check("reset_meas_mode", meas_mode, 0);
    check("reset_soft_rst_pulse", soft_rst_pulse, 0);
    rst_n = 1'b1;
    repeat (5) @(posedge clk);
    #1;

    fill(1, 8'h02); txn(8'h0A, 6'h2D);
    check("meas_after_write", meas_mode, 1);
    fill(1, 8'h00); txn(8'h0B, 6'h2D);
    fill(1, 8'hFF); txn(8'h0B, 6'h00);

    strobe(48'h060504030201);
    repeat (4) @(posedge clk);
    #1;
    m_vis = m_stage;
    strobe_idx = 3; strobe_val = 48'hA6A5A4A3A2A1;
    fill(6, 8'h00); txn(8'h0B, 6'h0E);
    strobe_idx = -1;
    fill(6, 8'h00); txn(8'h0B, 6'h0E);

    dq = '{8'h11, 8'h22}; txn(8'h0A, 6'h3F);
    fill(2, 8'h00); txn(8'h0B, 6'h3F);

    fill(1, 8'h02); txn(8'h0A, 6'h2D);
    fill(1, 8'h5A); txn(8'h0A, 6'h20);
    fill(1, 8'h52); txn(8'h0A, 6'h1F);
    check("meas_after_soft_reset", meas_mode, 0);
    fill(1, 8'h02); txn(8'h0A, 6'h2D);
    fill(1, 8'h51); txn(8'h0A, 6'h1F);
    fill(1, 8'h00); txn(8'h0B, 6'h20);
    fill(1, 8'h00); txn(8'h0B, 6'h2D);

    fill(1, 8'h33); txn(8'h0A, 6'h21);
    cs_n = 1'b0;
    repeat (HALF) @(posedge clk);
    #1;
    spi_bits(8'h0A, 8, rx);
    spi_bits(8'h21, 8, rx);
    spi_bits(8'hCC, 5, rx);
    cs_n = 1'b1;
    repeat (2 * HALF) @(posedge clk);
    #1;
    fill(2, 8'h00); txn(8'h0B, 6'h21);

    fill(3, 8'hFF); txn(8'h55, 6'h00);

    for (int it = 0; it < 24; it++) begin
      int op, n;
      logic [5:0] a;
      op = $urandom_range(0, 2);
      a  = 6'($urandom_range(0, 63));
      n  = $urandom_range(1, 4);
      dq.delete();
      for (int k = 0; k < n; k++) dq.push_back(8'($urandom));
      if (op == 0) txn(8'h0A, a);
      else if (op == 1) txn(8'h0B, a);
      else begin
        r64 = {$urandom(), $urandom()};
        strobe(r64[47:0]);
        repeat (4) @(posedge clk);
        #1;
      end
    end
    fill(64, 8'h00); txn(8'h0B, 6'h00);

    fill(1, 8'h02); txn(8'h0A, 6'h2D);
    cs_n = 1'b0;
    repeat (HALF) @(posedge clk);
    #1;
    spi_bits(8'h0B, 8, rx);
    spi_bits(8'h00, 8, rx);
    spi_bits(8'h00, 3, rx);
    check("read_before_reset", rx, 8'hA0);
    rst_n = 1'b0;
    #1;
    check("midread_reset_miso", miso, 0);
    check("midread_reset_miso_oe", miso_oe, 0);
    check("midread_reset_meas_mode", meas_mode, 0);
    m_reset();
    cs_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    fill(1, 8'h00); txn(8'h0B, 6'h2D);
    fill(2, 8'h00); txn(8'h0B, 6'h0E);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
